// File: rtl/rename_regfile_pkg.sv
// Shared widths, types and lookup result record for the rename register file.
package rename_regfile_pkg;
  localparam int REG_NUM = 32;
  localparam int NAME_W  = 5;
  localparam int NICK_W  = 5;
  localparam int DATA_W  = 32;

  typedef logic [NAME_W-1:0] name_t;
  typedef logic [NICK_W-1:0] nick_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam nick_t ZERO_NICK = '0;
  localparam name_t ZERO_REG  = '0;

  typedef struct packed {
    logic  rdy;
    data_t dt;
    nick_t nick;
  } lookup_t;

  function automatic lookup_t lookup_ready(input data_t dt);
    lookup_ready = '{rdy: 1'b1, dt: dt, nick: ZERO_NICK};
  endfunction
endpackage

// File: rtl/rename_regfile_if.sv
// ROB rename/commit inputs, mispredict flush, global enable and two dispatch lookup ports.
interface rename_regfile_if;
  import rename_regfile_pkg::*;

  logic  rdy;
  logic  clr;
  logic  rob_nick_en;
  nick_t rob_nick;
  name_t rob_regnm;
  logic  rf_en;
  name_t rf_regnm;
  data_t rf_dt;
  nick_t rf_nick;
  name_t dp_rs1;
  name_t dp_rs2;
  logic  dp_rs1_rdy;
  data_t dp_rs1_dt;
  nick_t dp_rs1_nick;
  logic  dp_rs2_rdy;
  data_t dp_rs2_dt;
  nick_t dp_rs2_nick;

  modport master (
    output rdy, clr, rob_nick_en, rob_nick, rob_regnm,
    output rf_en, rf_regnm, rf_dt, rf_nick, dp_rs1, dp_rs2,
    input  dp_rs1_rdy, dp_rs1_dt, dp_rs1_nick, dp_rs2_rdy, dp_rs2_dt, dp_rs2_nick
  );

  modport slave (
    input  rdy, clr, rob_nick_en, rob_nick, rob_regnm,
    input  rf_en, rf_regnm, rf_dt, rf_nick, dp_rs1, dp_rs2,
    output dp_rs1_rdy, dp_rs1_dt, dp_rs1_nick, dp_rs2_rdy, dp_rs2_dt, dp_rs2_nick
  );
endinterface

// File: rtl/rename_regfile_lookup.sv
// One source-operand lookup: register name -> committed data or producer tag, 0-cycle.
// RF_COMMIT_BYPASS_EN forwards a same-cycle matching commit straight to the result.
module rf_lookup_port
  import rename_regfile_pkg::*;
(
  input  logic               rst,
  input  name_t              name,
  input  data_t              dt_q  [REG_NUM],
  input  logic [REG_NUM-1:0] busy_q,
  input  nick_t              tag_q [REG_NUM],
  input  logic               commit_en,
  input  name_t              commit_regnm,
  input  data_t              commit_dt,
  input  nick_t              commit_nick,
  output lookup_t            res
);

`ifdef RF_COMMIT_BYPASS_EN
  logic byp_hit;
  assign byp_hit = commit_en && (commit_regnm == name) && (tag_q[name] == commit_nick);
`else
  logic byp_hit;
  logic unused_commit;
  assign byp_hit       = 1'b0;
  assign unused_commit = ^{commit_en, commit_regnm, commit_dt, commit_nick};
`endif

  always_comb begin
    res = lookup_ready('0);
    if (rst || name == ZERO_REG) begin
      res = lookup_ready('0);
    end else if (byp_hit) begin
      res = lookup_ready(commit_dt);
    end else if (busy_q[name]) begin
      res.rdy  = 1'b0;
      res.nick = tag_q[name];
    end else begin
      res.dt = dt_q[name];
    end
  end
endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename tags: 1-cycle commit/rename write, 0-cycle lookup.
// No backpressure; rdy low freezes state. Optional same-cycle commit forwarding: RF_COMMIT_BYPASS_EN.
module rename_regfile
  import rename_regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  rename_regfile_if.slave  bus
);

  data_t              dt_q  [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  nick_t              tag_q [REG_NUM];
  lookup_t            rs1_res;
  lookup_t            rs2_res;

  // Commit first, then flush/rename override busy/tag so the newer rename wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        dt_q[i]  <= '0;
        tag_q[i] <= ZERO_NICK;
      end
      busy_q <= '0;
    end else if (bus.rdy) begin
      if (bus.rf_en && bus.rf_regnm != ZERO_REG) begin
        dt_q[bus.rf_regnm] <= bus.rf_dt;
        if (tag_q[bus.rf_regnm] == bus.rf_nick) begin
          busy_q[bus.rf_regnm] <= 1'b0;
          tag_q[bus.rf_regnm]  <= ZERO_NICK;
        end
      end
      if (bus.clr) begin
        for (int i = 0; i < REG_NUM; i++) begin
          tag_q[i] <= ZERO_NICK;
        end
        busy_q <= '0;
      end else if (bus.rob_nick_en && bus.rob_regnm != ZERO_REG) begin
        busy_q[bus.rob_regnm] <= 1'b1;
        tag_q[bus.rob_regnm]  <= bus.rob_nick;
      end
    end
  end

  rf_lookup_port u_rs1 (
    .rst          (rst),
    .name         (bus.dp_rs1),
    .dt_q         (dt_q),
    .busy_q       (busy_q),
    .tag_q        (tag_q),
    .commit_en    (bus.rf_en),
    .commit_regnm (bus.rf_regnm),
    .commit_dt    (bus.rf_dt),
    .commit_nick  (bus.rf_nick),
    .res          (rs1_res)
  );

  rf_lookup_port u_rs2 (
    .rst          (rst),
    .name         (bus.dp_rs2),
    .dt_q         (dt_q),
    .busy_q       (busy_q),
    .tag_q        (tag_q),
    .commit_en    (bus.rf_en),
    .commit_regnm (bus.rf_regnm),
    .commit_dt    (bus.rf_dt),
    .commit_nick  (bus.rf_nick),
    .res          (rs2_res)
  );

  assign bus.dp_rs1_rdy  = rs1_res.rdy;
  assign bus.dp_rs1_dt   = rs1_res.dt;
  assign bus.dp_rs1_nick = rs1_res.nick;
  assign bus.dp_rs2_rdy  = rs2_res.rdy;
  assign bus.dp_rs2_dt   = rs2_res.dt;
  assign bus.dp_rs2_nick = rs2_res.nick;
endmodule

// File: tb/tb_rename_regfile.sv
// Directed vector table plus a hand-written commit/lookup collision sequence for rename_regfile.
module tb_rename_regfile;
  import rename_regfile_pkg::*;

  typedef struct packed {
    logic        rst;
    logic        clr;
    logic        en;
    logic        ne;
    logic [4:0]  nick;
    logic [4:0]  nreg;
    logic        ce;
    logic [4:0]  creg;
    logic [31:0] cdt;
    logic [4:0]  cnick;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [37:0] e1;
    logic [37:0] e2;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vq[$];

  rename_regfile_if bus();

  rename_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [37:0] rv(input logic [31:0] dt);
    rv = {1'b1, dt, 5'd0};
  endfunction

  function automatic logic [37:0] wv(input logic [4:0] n);
    wv = {1'b0, 32'd0, n};
  endfunction

  function automatic vec_t mk(input logic r, input logic c, input logic en, input logic ne,
                              input logic [4:0] nick, input logic [4:0] nreg, input logic ce,
                              input logic [4:0] creg, input logic [31:0] cdt, input logic [4:0] cnick,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [37:0] e1, input logic [37:0] e2);
    mk = '{rst: r, clr: c, en: en, ne: ne, nick: nick, nreg: nreg, ce: ce, creg: creg,
           cdt: cdt, cnick: cnick, rs1: rs1, rs2: rs2, e1: e1, e2: e2};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [37:0] got, input logic [37:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s%0d got rdy=%0d dt=%h nick=%0d exp rdy=%0d dt=%h nick=%0d",
               nm, idx, got[37], got[36:5], got[4:0], exp[37], exp[36:5], exp[4:0]);
    end
  endtask

  task automatic drive(input vec_t v);
    rst             = v.rst;
    bus.clr         = v.clr;
    bus.rdy         = v.en;
    bus.rob_nick_en = v.ne;
    bus.rob_nick    = v.nick;
    bus.rob_regnm   = v.nreg;
    bus.rf_en       = v.ce;
    bus.rf_regnm    = v.creg;
    bus.rf_dt       = v.cdt;
    bus.rf_nick     = v.cnick;
    bus.dp_rs1      = v.rs1;
    bus.dp_rs2      = v.rs2;
  endtask

  function automatic logic [37:0] rs1_out();
    rs1_out = {bus.dp_rs1_rdy, bus.dp_rs1_dt, bus.dp_rs1_nick};
  endfunction

  function automatic logic [37:0] rs2_out();
    rs2_out = {bus.dp_rs2_rdy, bus.dp_rs2_dt, bus.dp_rs2_nick};
  endfunction

  initial begin
    logic [37:0] exp_byp;
    checks   = 0;
    failures = 0;
    drive(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, rv(0), rv(0)));

    // rst clr en | ne nick nreg | ce creg cdt cnick | rs1 rs2 | exp rs1, exp rs2
    vq.push_back(mk(1, 0, 1, 0, 0, 0,  0, 0, 32'h0, 0,          5, 0,  rv(0), rv(0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 32'h0, 0,          5, 31, rv(0), rv(0)));
    vq.push_back(mk(0, 0, 1, 1, 3, 5,  0, 0, 32'h0, 0,          5, 0,  rv(0), rv(0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 32'h0, 0,          5, 5,  wv(3), wv(3)));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  1, 5, 32'hDEADBEEF, 3,   7, 0,  rv(0), rv(0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 32'h0, 0,          5, 0,  rv(32'hDEADBEEF), rv(0)));
    vq.push_back(mk(0, 0, 1, 1, 2, 7,  0, 0, 32'h0, 0,          7, 5,  rv(0), rv(32'hDEADBEEF)));
    vq.push_back(mk(0, 0, 1, 1, 4, 7,  0, 0, 32'h0, 0,          7, 0,  wv(2), rv(0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  1, 7, 32'h11, 2,         7, 5,  wv(4), rv(32'hDEADBEEF)));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 32'h0, 0,          7, 0,  wv(4), rv(0)));
    vq.push_back(mk(0, 0, 1, 1, 6, 9,  0, 0, 32'h0, 0,          9, 0,  rv(0), rv(0)));
    vq.push_back(mk(0, 0, 1, 1, 7, 9,  1, 9, 32'h22, 6,         7, 5,  wv(4), rv(32'hDEADBEEF)));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 32'h0, 0,          9, 0,  wv(7), rv(0)));
    vq.push_back(mk(0, 0, 1, 1, 1, 1,  0, 0, 32'h0, 0,          1, 0,  rv(0), rv(0)));
    vq.push_back(mk(0, 0, 1, 1, 2, 2,  0, 0, 32'h0, 0,          1, 0,  wv(1), rv(0)));
    vq.push_back(mk(0, 1, 1, 1, 5, 4,  1, 3, 32'h33, 1,         2, 3,  wv(2), rv(0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 32'h0, 0,          1, 2,  rv(0), rv(0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 32'h0, 0,          3, 4,  rv(32'h33), rv(0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 32'h0, 0,          7, 9,  rv(32'h11), rv(32'h22)));
    vq.push_back(mk(0, 0, 1, 1, 3, 0,  1, 0, 32'h55, 3,         0, 0,  rv(0), rv(0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 32'h0, 0,          0, 0,  rv(0), rv(0)));
    vq.push_back(mk(0, 0, 0, 1, 8, 6,  1, 5, 32'h99, 3,         6, 5,  rv(0), rv(32'hDEADBEEF)));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 32'h0, 0,          6, 5,  rv(0), rv(32'hDEADBEEF)));
    vq.push_back(mk(0, 0, 1, 1, 9, 10, 0, 0, 32'h0, 0,          10, 0, rv(0), rv(0)));
    vq.push_back(mk(1, 1, 1, 1, 2, 10, 0, 0, 32'h0, 0,          10, 5, rv(0), rv(0)));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 32'h0, 0,          10, 5, rv(0), rv(0)));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk("vec_rs1_", i, rs1_out(), vq[i].e1);
      chk("vec_rs2_", i, rs2_out(), vq[i].e2);
    end

    // Commit of x5 seen by a lookup of x5 in the same cycle.
`ifdef RF_COMMIT_BYPASS_EN
    exp_byp = rv(32'hCAFE);
`else
    exp_byp = wv(3);
`endif
    @(negedge clk);
    drive(mk(0, 0, 1, 1, 3, 5, 0, 0, 32'h0, 0, 5, 0, rv(0), rv(0)));
    #1;
    chk("byp_pre", 0, rs1_out(), rv(0));
    @(negedge clk);
    drive(mk(0, 0, 1, 0, 0, 0, 1, 5, 32'hCAFE, 3, 5, 0, rv(0), rv(0)));
    #1;
    chk("byp_same", 0, rs1_out(), exp_byp);
    chk("byp_x0", 0, rs2_out(), rv(0));
    @(negedge clk);
    drive(mk(0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 5, 5, rv(0), rv(0)));
    #1;
    chk("byp_post", 0, rs1_out(), rv(32'hCAFE));
    chk("byp_post", 1, rs2_out(), rv(32'hCAFE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
